// File: rtl/cga_pkg.sv
// Shared types for the CGA VRAM arbiter: bus widths, default masks,
// read-FSM state encoding and the posted-write FIFO entry.
package cga_pkg;

    localparam int VRAM_AW = 19;
    localparam int CPU_AW  = 15;

    localparam logic [CPU_AW-1:0] MASK_CGA   = 15'h3FFF;
    localparam logic [CPU_AW-1:0] MASK_TANDY = 15'h7FFF;

    typedef enum logic [2:0] {
        RD_IDLE,
        RD_WAIT,
        RD_ISSUE,
        RD_CAPT,
        RD_HOLD
    } rd_state_t;

    typedef struct packed {
        logic [CPU_AW-1:0] addr;
        logic [7:0]        data;
    } wr_entry_t;

endpackage

// File: rtl/cga_vram_arbiter_if.sv
// ISA framebuffer-window bus between the CPU side (master) and the arbiter (slave).
// Carries address, decode, async read/write strobes, write data, read data and ready.
interface cga_vram_arbiter_if
    import cga_pkg::*;
    ();

    logic [CPU_AW-1:0] bus_a;
    logic              bus_mem_cs;
    logic              bus_memr_l;
    logic              bus_memw_l;
    logic [7:0]        bus_d;
    logic [7:0]        bus_out_mem;
    logic              bus_rdy;

    modport master (
        output bus_a, bus_mem_cs, bus_memr_l, bus_memw_l, bus_d,
        input  bus_out_mem, bus_rdy
    );

    modport slave (
        input  bus_a, bus_mem_cs, bus_memr_l, bus_memw_l, bus_d,
        output bus_out_mem, bus_rdy
    );

endinterface

// File: rtl/cga_wr_fifo.sv
// Posted-write FIFO: push/pop/full/empty/level, head visible on dout.
// Full/empty come from the level counter; pointers wrap modulo DEPTH.
module cga_wr_fifo
    import cga_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  wr_entry_t                din,
    input  logic                     pop,
    output wr_entry_t                dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    wr_entry_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    // A push into a full FIFO is legal when the head leaves in the same clk.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LW'(do_push) - LW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/cga_vram_arbiter.sv
// Shares one VRAM between video fetches (always win) and the ISA CPU path.
// Ports: clk/rst_n, bus (ISA slave), video_slot/video_addr, ram_* , fifo_level.
module cga_vram_arbiter
    import cga_pkg::*;
#(
    parameter int                FIFO_DEPTH   = 4,
    parameter logic [CPU_AW-1:0] VRAM_MASK    = MASK_CGA,
    parameter bit                USE_BUS_WAIT = 1'b1
) (
    input  logic                        clk,
    input  logic                        rst_n,
    cga_vram_arbiter_if.slave           bus,
    input  logic                        video_slot,
    input  logic [VRAM_AW-1:0]          video_addr,
    output logic [VRAM_AW-1:0]          ram_a,
    output logic                        ram_we_l,
    output logic [7:0]                  ram_dout,
    input  logic [7:0]                  ram_din,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int PAD = VRAM_AW - CPU_AW;

    // [0],[1] synchronise; [2] is the previous synced value for edge detect
    logic [2:0]        memr_sync;
    logic [2:0]        memw_sync;
    logic              rd_edge;
    logic              wr_edge;

    rd_state_t         rd_state;
    rd_state_t         rd_next;
    logic [CPU_AW-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              rd_start;
    logic              rd_busy;

    logic              wr_stall;
    logic              wr_stall_next;
    logic              wr_go;

    logic              push;
    logic              pop;
    logic              fifo_full;
    logic              fifo_empty;
    wr_entry_t         push_entry;
    wr_entry_t         head;

    assign rd_edge = !memr_sync[1] && memr_sync[2] && bus.bus_mem_cs;
    assign wr_edge = !memw_sync[1] && memw_sync[2] && bus.bus_mem_cs;

    // A write edge wins over a simultaneous read edge.
    assign rd_start = rd_edge && !wr_edge && (rd_state == RD_IDLE);
    assign rd_busy  = (rd_state == RD_WAIT) || (rd_state == RD_ISSUE) ||
                      (rd_state == RD_CAPT);

    // Drain only in clks the sequencer leaves free and the read is not on the bus.
    assign pop   = !video_slot && !fifo_empty && (rd_state != RD_ISSUE);
    assign wr_go = wr_edge || wr_stall;
    assign push  = wr_go && (!fifo_full || pop);

    assign push_entry = '{addr: bus.bus_a & VRAM_MASK, data: bus.bus_d};

    assign bus.bus_out_mem = rd_data;
    assign bus.bus_rdy     = USE_BUS_WAIT ? !(wr_stall || rd_busy) : 1'b1;

    cga_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .din   (push_entry),
        .pop   (pop),
        .dout  (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .level (fifo_level)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            memr_sync <= '1;
            memw_sync <= '1;
            rd_state  <= RD_IDLE;
            rd_addr   <= '0;
            rd_data   <= '0;
            wr_stall  <= 1'b0;
        end else begin
            memr_sync <= {memr_sync[1:0], bus.bus_memr_l};
            memw_sync <= {memw_sync[1:0], bus.bus_memw_l};
            rd_state  <= rd_next;
            wr_stall  <= wr_stall_next;
            if (rd_start) rd_addr <= bus.bus_a & VRAM_MASK;
            // ram_din reflects the address driven in RD_ISSUE, even if
            // the sequencer owns the bus in this clk.
            if (rd_state == RD_CAPT) rd_data <= ram_din;
        end
    end

    always_comb begin
        rd_next       = rd_state;
        wr_stall_next = wr_go && !push;
        unique case (rd_state)
            RD_IDLE:  if (rd_start) rd_next = RD_WAIT;
            RD_WAIT:  if (fifo_empty && !video_slot) rd_next = RD_ISSUE;
            // Hold the address until a clk the sequencer does not own.
            RD_ISSUE: if (!video_slot) rd_next = RD_CAPT;
            RD_CAPT:  rd_next = RD_HOLD;
            RD_HOLD:  if (memr_sync[1]) rd_next = RD_IDLE;
            default:  rd_next = RD_IDLE;
        endcase
    end

    always_comb begin
        ram_a    = '0;
        ram_we_l = 1'b1;
        ram_dout = '0;
        if (video_slot) begin
            ram_a = video_addr;
        end else if (rd_state == RD_ISSUE) begin
            ram_a = {{PAD{1'b0}}, rd_addr};
        end else if (pop) begin
            ram_a    = {{PAD{1'b0}}, head.addr};
            ram_we_l = 1'b0;
            ram_dout = head.data;
        end
    end

endmodule
